// File: rtl/uart_frame_streamer_if.sv
// -----------------------------------------------------------------------------
// uart_frame_streamer_if
// Groups the streamer's control, frame-buffer and UART transmitter signals.
//
//   start    : begin a frame (control -> streamer)
//   abort    : stop the frame at the next byte boundary (control -> streamer)
//   busy     : frame in progress (streamer -> control)
//   done     : one-cycle completion pulse (streamer -> control)
//   aborted  : qualifies done when the frame was aborted (streamer -> control)
//   mem_addr : frame-buffer read address (streamer -> RAM)
//   mem_rd   : frame-buffer read enable, data valid next cycle (streamer -> RAM)
//   mem_data : frame-buffer read data (RAM -> streamer)
//   tx_data  : byte to the transmitter data_in (streamer -> UART)
//   tx_send  : one-cycle send pulse (streamer -> UART)
//   tx_busy  : transmitter busy (UART -> streamer)
//
// Modport master is the streamer; slave is its environment.
// -----------------------------------------------------------------------------
interface uart_frame_streamer_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic [7:0]        tx_data;
    logic              tx_send;
    logic              tx_busy;

    modport master (
        input  start,
        input  abort,
        input  mem_data,
        input  tx_busy,
        output busy,
        output done,
        output aborted,
        output mem_addr,
        output mem_rd,
        output tx_data,
        output tx_send
    );

    modport slave (
        output start,
        output abort,
        output mem_data,
        output tx_busy,
        input  busy,
        input  done,
        input  aborted,
        input  mem_addr,
        input  mem_rd,
        input  tx_data,
        input  tx_send
    );
endinterface

// File: rtl/uart_frame_streamer.sv
// -----------------------------------------------------------------------------
// uart_frame_streamer
// Streams one frame from a synchronous-read frame buffer to a UART transmitter:
// HDR0, HDR1, every pixel byte (address 0 upward), then an 8-bit wrapping
// checksum of the pixel bytes. Each byte is handed over with a one-cycle send
// pulse, then the streamer waits for the transmitter's busy to rise and fall
// before moving on, so bytes are never dropped, duplicated or truncated.
//
// Ports:
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset
//   io_bus : uart_frame_streamer_if.master (control, frame-buffer, UART signals)
//
// All interface outputs are registered.
// -----------------------------------------------------------------------------
module uart_frame_streamer #(
    parameter int unsigned IMG_W  = 128,
    parameter int unsigned IMG_H  = 128,
    parameter int unsigned ADDR_W = 14,
    parameter logic [7:0]  HDR0   = 8'hAA,
    parameter logic [7:0]  HDR1   = 8'h55
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    uart_frame_streamer_if.master  io_bus
);

    localparam int unsigned       NumPix  = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NumPix - 1);

    typedef enum logic [3:0] {
        StIdle,
        StHdr,
        StFetch,
        StRdWait,
        StSend,
        StAck,
        StDrain,
        StCsum,
        StFin
    } state_e;

    // Which kind of byte is currently on tx_data; decides where DRAIN goes.
    typedef enum logic [1:0] {
        KindHdr,
        KindPix,
        KindCsum
    } kind_e;

    state_e            r_state;
    kind_e             r_kind;
    logic              r_hdr_sel;   // 0: HDR0 pending/sent, 1: HDR1
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_csum;
    logic              r_abort;     // sticky abort request

    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic [7:0]        r_tx_data;
    logic              r_tx_send;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_kind     <= KindHdr;
            r_hdr_sel  <= 1'b0;
            r_idx      <= '0;
            r_csum     <= 8'h00;
            r_abort    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_send  <= 1'b0;
        end else begin
            // Pulse outputs default low; set only on entry to their state.
            r_tx_send <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;

            if (r_busy && io_bus.abort) begin
                r_abort <= 1'b1;
            end

            case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_busy    <= 1'b1;
                        r_idx     <= '0;
                        r_csum    <= 8'h00;
                        r_hdr_sel <= 1'b0;
                        // An abort arriving with start is honoured after HDR0.
                        r_abort   <= io_bus.abort;
                        r_state   <= StHdr;
                    end
                end

                StHdr: begin
                    r_tx_data <= r_hdr_sel ? HDR1 : HDR0;
                    r_kind    <= KindHdr;
                    r_tx_send <= 1'b1;
                    r_state   <= StSend;
                end

                StFetch: begin
                    r_state <= StRdWait;
                end

                StRdWait: begin
                    r_tx_data <= io_bus.mem_data;
                    r_csum    <= r_csum + io_bus.mem_data;
                    r_kind    <= KindPix;
                    r_tx_send <= 1'b1;
                    r_state   <= StSend;
                end

                StSend: begin
                    r_state <= StAck;
                end

                StAck: begin
                    if (io_bus.tx_busy) begin
                        r_state <= StDrain;
                    end
                end

                StDrain: begin
                    if (!io_bus.tx_busy) begin
                        if (r_abort || (r_kind == KindCsum)) begin
                            r_done    <= 1'b1;
                            r_aborted <= r_abort;
                            r_busy    <= 1'b0;
                            r_state   <= StFin;
                        end else if (r_kind == KindHdr) begin
                            if (!r_hdr_sel) begin
                                r_hdr_sel <= 1'b1;
                                r_state   <= StHdr;
                            end else begin
                                r_mem_addr <= r_idx;
                                r_mem_rd   <= 1'b1;
                                r_state    <= StFetch;
                            end
                        end else if (r_idx == LastIdx) begin
                            r_state <= StCsum;
                        end else begin
                            r_idx      <= r_idx + ADDR_W'(1);
                            r_mem_addr <= r_idx + ADDR_W'(1);
                            r_mem_rd   <= 1'b1;
                            r_state    <= StFetch;
                        end
                    end
                end

                StCsum: begin
                    r_tx_data <= r_csum;
                    r_kind    <= KindCsum;
                    r_tx_send <= 1'b1;
                    r_state   <= StSend;
                end

                StFin: begin
                    r_state <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;
    assign io_bus.aborted  = r_aborted;
    assign io_bus.mem_addr = r_mem_addr;
    assign io_bus.mem_rd   = r_mem_rd;
    assign io_bus.tx_data  = r_tx_data;
    assign io_bus.tx_send  = r_tx_send;

endmodule

// File: tb/tb_uart_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_streamer
// Drives uart_frame_streamer (IMG_W=4, IMG_H=2) with a frame-buffer model and a
// behavioural UART transmitter whose busy latency and byte time are adjustable.
// Expected byte streams are built from the frame contents directly.
// -----------------------------------------------------------------------------
module tb_uart_frame_streamer;

    localparam int unsigned IMG_W  = 4;
    localparam int unsigned IMG_H  = 2;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NPIX   = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_frame_streamer_if #(.ADDR_W(ADDR_W)) bus ();

    uart_frame_streamer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W),
        .HDR0  (8'hAA),
        .HDR1  (8'h55)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Frame buffer: synchronous read, data one cycle after mem_rd.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    // Transmitter model: latches a byte on each send, raises busy after
    // lat_cfg extra cycles, keeps it for btime_cfg cycles.
    int         lat_cfg   = 0;
    int         btime_cfg = 40;
    logic       m_busy    = 1'b0;
    logic       m_pend    = 1'b0;
    logic       prev_send = 1'b0;
    int         m_lat     = 0;
    int         m_cnt     = 0;
    logic [7:0] m_byte    = 8'h00;
    int         send_cnt  = 0;
    int         viol      = 0;
    int         hold_viol = 0;
    logic [7:0] rxq [$];

    assign bus.tx_busy = m_busy;

    always @(posedge clk) begin
        prev_send <= bus.tx_send;
        if (bus.tx_send) begin
            send_cnt <= send_cnt + 1;
            if (prev_send || m_busy || m_pend) viol <= viol + 1;
            rxq.push_back(bus.tx_data);
            m_byte <= bus.tx_data;
            if (lat_cfg == 0) begin
                m_busy <= 1'b1;
                m_cnt  <= btime_cfg;
            end else begin
                m_pend <= 1'b1;
                m_lat  <= lat_cfg;
            end
        end else if (m_pend) begin
            if (m_lat == 1) begin
                m_pend <= 1'b0;
                m_busy <= 1'b1;
                m_cnt  <= btime_cfg;
            end else begin
                m_lat <= m_lat - 1;
            end
        end else if (m_busy) begin
            if (bus.busy && (bus.tx_data != m_byte)) hold_viol <= hold_viol + 1;
            if (m_cnt == 1) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
    end

    int   done_cnt  = 0;
    logic last_ab   = 1'b0;
    logic last_busy = 1'b0;
    always @(posedge clk) begin
        if (bus.done) begin
            done_cnt  <= done_cnt + 1;
            last_ab   <= bus.aborted;
            last_busy <= bus.busy;
        end
    end

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_busy"},     bus.busy,     0);
        check_eq({pfx, "_done"},     bus.done,     0);
        check_eq({pfx, "_aborted"},  bus.aborted,  0);
        check_eq({pfx, "_tx_send"},  bus.tx_send,  0);
        check_eq({pfx, "_tx_data"},  bus.tx_data,  0);
        check_eq({pfx, "_mem_rd"},   bus.mem_rd,   0);
        check_eq({pfx, "_mem_addr"}, bus.mem_addr, 0);
    endtask

    task automatic wait_tx_idle();
        for (int i = 0; i < 400 && (m_busy || m_pend); i++) @(negedge clk);
    endtask

    // abort_at < 0: no abort; 0: abort together with start; k > 0: abort once
    // k bytes have been handed to the transmitter.
    task automatic run_frame(input string name, input int abort_at, input bit spurious);
        logic [7:0] exp [$];
        int         sum;
        int         nexp;
        int         rx0;
        int         d0;
        int         s0;
        int         got_n;
        bit         seen;
        wait_tx_idle();
        exp = {};
        exp.push_back(8'hAA);
        exp.push_back(8'h55);
        sum = 0;
        for (int i = 0; i < NPIX; i++) begin
            exp.push_back(mem[i]);
            sum += int'(mem[i]);
        end
        exp.push_back(8'(sum % 256));
        nexp = (abort_at < 0) ? NPIX + 3 : ((abort_at == 0) ? 1 : abort_at);
        rx0 = rxq.size();
        d0  = done_cnt;
        s0  = send_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = (abort_at == 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            if (!seen) begin
                bus.abort = (abort_at > 0) && (rxq.size() - rx0 >= abort_at);
                bus.start = spurious && ($urandom_range(0, 3) == 0);
            end else begin
                bus.start = 1'b0;
                bus.abort = 1'b0;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_eq({name, "_done_seen"}, seen, 1);
        repeat (60) @(negedge clk);
        got_n = rxq.size() - rx0;
        check_eq({name, "_byte_count"}, got_n, nexp);
        for (int k = 0; k < nexp && k < got_n; k++)
            check_eq($sformatf("%s_byte%0d", name, k), rxq[rx0 + k], exp[k]);
        check_eq({name, "_done_pulses"}, done_cnt - d0, 1);
        check_eq({name, "_aborted"}, last_ab, (abort_at >= 0));
        check_eq({name, "_busy_at_done"}, last_busy, 0);
        check_eq({name, "_busy_after"}, bus.busy, 0);
        check_eq({name, "_send_count"}, send_cnt - s0, nexp);
    endtask

    initial begin
        int rx0;
        int d0;
        int s0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_rst");

        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
        run_frame("ramp", -1, 1'b0);

        for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
        run_frame("all_ff", -1, 1'b0);

        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
        lat_cfg = 3;
        run_frame("late_busy", -1, 1'b0);
        lat_cfg = 0;

        // Abort while the pixel at address 2 is on the line.
        run_frame("abort_pix2", 5, 1'b0);
        run_frame("abort_start", 0, 1'b0);

        // Reset while HDR1 is being transmitted.
        wait_tx_idle();
        rx0 = rxq.size();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 2000 && (rxq.size() - rx0 < 2); c++) @(negedge clk);
        check_eq("midrst_hdr1_started", rxq.size() - rx0, 2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        d0 = done_cnt;
        s0 = send_cnt;
        repeat (80) @(negedge clk);
        check_eq("midrst_no_done", done_cnt - d0, 0);
        check_eq("midrst_no_send", send_cnt - s0, 0);
        run_frame("post_rst", -1, 1'b0);

        run_frame("spurious_start", -1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            lat_cfg   = $urandom_range(0, 4);
            btime_cfg = $urandom_range(2, 40);
            run_frame($sformatf("rand%0d", r), -1, 1'b1);
        end
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        lat_cfg   = $urandom_range(0, 2);
        btime_cfg = $urandom_range(2, 20);
        run_frame("rand_abort", $urandom_range(1, 10), 1'b0);

        check_eq("send_spacing", viol, 0);
        check_eq("tx_data_hold", hold_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
